// File: rtl/seq_shift_if.sv
// seq_shift_if: start/busy/done handshake and operand/result bus for seq_shift_unit
// master drives start, op, data_in, shamt; slave returns busy, done, result
interface seq_shift_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    modport master (output start, op, data_in, shamt, input busy, done, result);
    modport slave  (input start, op, data_in, shamt, output busy, done, result);
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multicycle one-bit-per-clock SLL/SRL/SRA unit with start/busy/done handshake
// ports: clk, reset (sync, active-high), bus (slave: start/op/data_in/shamt in, busy/done/result out)
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    seq_shift_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work, work_nxt, res;
    logic [SHAMT_W-1:0] count, count_nxt;
    logic [1:0]         op_reg, op_nxt;
    logic               accept;
    always_comb begin
        accept    = bus.start && (state != SHIFT);
        state_nxt = state;
        work_nxt  = work;
        count_nxt = count;
        op_nxt    = op_reg;
        if (accept) begin
            work_nxt  = bus.data_in;
            count_nxt = bus.shamt;
            op_nxt    = bus.op;
            state_nxt = (bus.shamt == '0 || bus.op == 2'b11) ? DONE : SHIFT;
        end else if (state == SHIFT) begin
            // right shifts fill with the sign bit only for SRA (op_reg[1])
            work_nxt  = (op_reg == 2'b00) ? {work[WIDTH-2:0], 1'b0}
                                          : {op_reg[1] & work[WIDTH-1], work[WIDTH-1:1]};
            count_nxt = count - 1'b1;
            state_nxt = (count == 1) ? DONE : SHIFT;
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            op_reg <= '0;
            res    <= '0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            count  <= count_nxt;
            op_reg <= op_nxt;
            if (state_nxt == DONE) res <= work_nxt;
        end
    end
    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = res;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: randomized scoreboard bench for seq_shift_unit against an arithmetic shift model
module tb_seq_shift_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_rst = 1'b1;
    always #5 clk = ~clk;

    seq_shift_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] res;
        int          due;
        int          nbusy;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          busy_cnt = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int n);
        logic signed [31:0] s;
        s = d;
        case (op)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return 32'(s >>> n);
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: pops the scoreboard on every done pulse, otherwise checks result holds
    always @(negedge clk) begin
        if (!in_rst) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_done: done=1 with no operation pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", bus.result, e.res);
                    check("latency", 32'(cyc), 32'(e.due));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.nbusy));
                end
                busy_cnt = 0;
                last_res = bus.result;
            end else begin
                check("result_hold", bus.result, last_res);
            end
        end
    end

    // issue one operation, then ride through its shift phase while poking ignored starts;
    // returns at the falling edge of the done cycle so the caller may chain back-to-back
    task automatic go(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        exp_t e;
        int   n;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = d;
        bus.shamt   = sh;
        @(posedge clk);
        #1;
        n       = (op == 2'b11) ? 0 : int'(sh);
        e.res   = model(op, d, int'(sh));
        e.due   = cyc + n;
        e.nbusy = n;
        q.push_back(e);
        bus.start = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            bus.start = (i < n) && ($urandom_range(3) == 0);
            bus.op      = 2'($urandom);
            bus.data_in = $urandom;
            bus.shamt   = 5'($urandom);
        end
        bus.start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        in_rst    = 1'b1;
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        busy_cnt = 0;
        last_res = '0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        reset  = 1'b0;
        in_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = '0;
        bus.shamt   = '0;
        do_reset(3);
        @(negedge clk);
        go(2'b00, 32'h0000_FFFF, 5'd2);
        @(negedge clk);
        go(2'b10, 32'hFFFF_9FFF, 5'd4);
        go(2'b01, 32'hFFFF_9FFF, 5'd4);
        go(2'b00, 32'h1234_5678, 5'd0);
        go(2'b10, 32'h8000_0000, 5'd31);
        @(negedge clk);
        go(2'b11, 32'hDEAD_BEEF, 5'd7);
        @(negedge clk);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.data_in = 32'hF0F0_1234;
        bus.shamt   = 5'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        do_reset(1);
        repeat (15) @(negedge clk);
        go(2'b01, 32'hF0F0_1234, 5'd10);
        repeat (150) begin
            if ($urandom_range(2) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
            go(2'($urandom), $urandom, 5'($urandom));
        end
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d operations never completed, expected 0", q.size());
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
